// File: rtl/i2c_reg_seq_pkg.sv
// Shared constants, state encoding and request step table for the I2C register-access sequencer.
package i2c_reg_seq_pkg;

    localparam logic [2:0] PRER_LO = 3'd0;
    localparam logic [2:0] PRER_HI = 3'd1;
    localparam logic [2:0] CTR     = 3'd2;
    localparam logic [2:0] TXR_RXR = 3'd3;
    localparam logic [2:0] CR_SR   = 3'd4;

    localparam int CR_STA  = 7;
    localparam int CR_STO  = 6;
    localparam int CR_RD   = 5;
    localparam int CR_WR   = 4;
    localparam int CR_ACK  = 3;
    localparam int CR_IACK = 0;

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_TIP   = 1;
    localparam int SR_IF    = 0;

    localparam int CTR_EN  = 7;
    localparam int CTR_IEN = 6;

    localparam logic [7:0] CMD_STA_WR      = 8'h91;
    localparam logic [7:0] CMD_WR          = 8'h11;
    localparam logic [7:0] CMD_STO_WR      = 8'h51;
    localparam logic [7:0] CMD_STO_RD_NACK = 8'h69;
    localparam logic [7:0] CMD_STO         = 8'h41;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        ST_INIT_PL   = 4'd0,
        ST_INIT_PH   = 4'd1,
        ST_INIT_CTR  = 4'd2,
        ST_IDLE      = 4'd3,
        ST_WR_TXR    = 4'd4,
        ST_WR_CR     = 4'd5,
        ST_WAIT      = 4'd6,
        ST_RD_RXR    = 4'd7,
        ST_STOP_CR   = 4'd8,
        ST_STOP_WAIT = 4'd9,
        ST_RESP      = 4'd10
    } state_e;

    // Writes use steps 0..2, reads use steps 0..3 (step 3 has no TXR byte).
    function automatic logic [7:0] step_cr(input logic rd, input logic [1:0] step);
        logic [7:0] cr;
        case (step)
            2'd0:    cr = CMD_STA_WR;
            2'd1:    cr = CMD_WR;
            2'd2:    cr = rd ? CMD_STA_WR : CMD_STO_WR;
            default: cr = CMD_STO_RD_NACK;
        endcase
        return cr;
    endfunction

    function automatic logic [7:0] step_txr(input logic rd, input logic [1:0] step,
                                            input logic [6:0] dev, input logic [7:0] reg_addr,
                                            input logic [7:0] wdata);
        logic [7:0] txr;
        case (step)
            2'd0:    txr = {dev, 1'b0};
            2'd1:    txr = reg_addr;
            2'd2:    txr = rd ? {dev, 1'b1} : wdata;
            default: txr = 8'h00;
        endcase
        return txr;
    endfunction

    function automatic logic step_has_txr(input logic [1:0] step);
        return step != 2'd3;
    endfunction

    function automatic logic step_last(input logic rd, input logic [1:0] step);
        return rd ? (step == 2'd3) : (step == 2'd2);
    endfunction

endpackage

// File: rtl/i2c_reg_seq_if.sv
// WISHBONE bus between the sequencer (master) and the byte-level I2C master core (slave).
interface i2c_reg_seq_if;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i;
    logic       wb_inta_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_inta_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_inta_i
    );
endinterface

// File: rtl/i2c_reg_seq_wbm.sv
// Single-access WISHBONE master: launches one cycle on start and reports done on the acknowledging edge.
module i2c_reg_seq_wbm (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   addr,
    input  logic         we,
    input  logic [7:0]   wdata,
    output logic         busy,
    output logic         done,
    output logic [7:0]   rdata,
    i2c_reg_seq_if.master wb
);

    logic       cyc_r;
    logic       we_r;
    logic [2:0] adr_r;
    logic [7:0] dat_r;

    // Bus cycle register: address/data stay frozen while the cycle is open.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_r <= 1'b0;
            we_r  <= 1'b0;
            adr_r <= 3'd0;
            dat_r <= 8'h00;
        end else if (cyc_r) begin
            if (wb.wb_ack_i) begin
                cyc_r <= 1'b0;
                we_r  <= 1'b0;
            end
        end else if (start) begin
            cyc_r <= 1'b1;
            we_r  <= we;
            adr_r <= addr;
            dat_r <= wdata;
        end
    end

    assign busy  = cyc_r;
    assign done  = cyc_r && wb.wb_ack_i;
    assign rdata = wb.wb_dat_i;

    assign wb.wb_cyc_o = cyc_r;
    assign wb.wb_stb_o = cyc_r;
    assign wb.wb_we_o  = we_r;
    assign wb.wb_adr_o = adr_r;
    assign wb.wb_dat_o = dat_r;

endmodule

// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: turns one read/write request into the WISHBONE program for the I2C core.
// Build option I2C_REG_SEQ_IRQ_WAIT_EN: wait for the core interrupt instead of polling SR.
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter logic [15:0] POLL_MAX = 16'd65535
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rd,
    input  logic [6:0]    req_dev,
    input  logic [7:0]    req_reg,
    input  logic [7:0]    req_wdata,
    output logic          rsp_valid,
    output logic [7:0]    rsp_rdata,
    output logic [1:0]    rsp_err,
    i2c_reg_seq_if.master wb
);

`ifdef I2C_REG_SEQ_IRQ_WAIT_EN
    localparam logic [7:0] CTR_INIT = 8'hC0;
`else
    localparam logic [7:0] CTR_INIT = 8'h80;
`endif

    state_e      state_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [7:0]  rsp_rdata_r;
    logic [1:0]  rsp_err_r;
    logic        rd_r;
    logic [6:0]  dev_r;
    logic [7:0]  reg_r;
    logic [7:0]  wdata_r;
    logic [1:0]  step_r;
    logic [1:0]  err_r;
    logic [15:0] poll_cnt_r;
`ifdef I2C_REG_SEQ_IRQ_WAIT_EN
    logic        irq_seen_r;
`else
    logic        unused_inta_s;
    assign unused_inta_s = wb.wb_inta_i;
`endif

    logic        bus_start_s;
    logic [2:0]  bus_adr_s;
    logic        bus_we_s;
    logic [7:0]  bus_dat_s;
    logic        bus_busy_s;
    logic        bus_done_s;
    logic [7:0]  bus_rdata_s;
    logic [7:0]  cr_s;
    logic [1:0]  next_step_s;
    logic        last_s;
    logic        nack_s;
    logic        sr_if_s;
    logic        wait_tick_s;
    logic        timeout_s;

    // Bus access requested by the current state.
    always_comb begin
        bus_start_s = 1'b0;
        bus_adr_s   = 3'd0;
        bus_we_s    = 1'b0;
        bus_dat_s   = 8'h00;
        case (state_r)
            ST_INIT_PL: begin
                bus_start_s = 1'b1;
                bus_adr_s   = PRER_LO;
                bus_we_s    = 1'b1;
                bus_dat_s   = PRESCALE[7:0];
            end
            ST_INIT_PH: begin
                bus_start_s = 1'b1;
                bus_adr_s   = PRER_HI;
                bus_we_s    = 1'b1;
                bus_dat_s   = PRESCALE[15:8];
            end
            ST_INIT_CTR: begin
                bus_start_s = 1'b1;
                bus_adr_s   = CTR;
                bus_we_s    = 1'b1;
                bus_dat_s   = CTR_INIT;
            end
            ST_WR_TXR: begin
                bus_start_s = 1'b1;
                bus_adr_s   = TXR_RXR;
                bus_we_s    = 1'b1;
                bus_dat_s   = step_txr(rd_r, step_r, dev_r, reg_r, wdata_r);
            end
            ST_WR_CR: begin
                bus_start_s = 1'b1;
                bus_adr_s   = CR_SR;
                bus_we_s    = 1'b1;
                bus_dat_s   = step_cr(rd_r, step_r);
            end
            ST_WAIT: begin
`ifdef I2C_REG_SEQ_IRQ_WAIT_EN
                bus_start_s = irq_seen_r;
`else
                bus_start_s = 1'b1;
`endif
                bus_adr_s   = CR_SR;
            end
            ST_RD_RXR: begin
                bus_start_s = 1'b1;
                bus_adr_s   = TXR_RXR;
            end
            ST_STOP_CR: begin
                bus_start_s = 1'b1;
                bus_adr_s   = CR_SR;
                bus_we_s    = 1'b1;
                bus_dat_s   = CMD_STO;
            end
            ST_STOP_WAIT: begin
                bus_start_s = 1'b1;
                bus_adr_s   = CR_SR;
            end
            default: begin
                bus_start_s = 1'b0;
            end
        endcase
    end

    // Step decode and wait-loop qualifiers.
    always_comb begin
        cr_s        = step_cr(rd_r, step_r);
        next_step_s = step_r + 2'd1;
        last_s      = step_last(rd_r, step_r);
        nack_s      = cr_s[CR_WR] && bus_rdata_s[SR_RXACK];
        timeout_s   = (poll_cnt_r + 16'd1) == POLL_MAX;
`ifdef I2C_REG_SEQ_IRQ_WAIT_EN
        sr_if_s     = 1'b1;
        wait_tick_s = !irq_seen_r && !wb.wb_inta_i;
`else
        sr_if_s     = bus_rdata_s[SR_IF];
        wait_tick_s = bus_done_s;
`endif
    end

    i2c_reg_seq_wbm u_wbm (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .start (bus_start_s),
        .addr  (bus_adr_s),
        .we    (bus_we_s),
        .wdata (bus_dat_s),
        .busy  (bus_busy_s),
        .done  (bus_done_s),
        .rdata (bus_rdata_s),
        .wb    (wb)
    );

    // Sequencer FSM with registered request/response outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_r     <= ST_INIT_PL;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= ERR_OK;
            rd_r        <= 1'b0;
            dev_r       <= 7'd0;
            reg_r       <= 8'h00;
            wdata_r     <= 8'h00;
            step_r      <= 2'd0;
            err_r       <= ERR_OK;
            poll_cnt_r  <= 16'd0;
`ifdef I2C_REG_SEQ_IRQ_WAIT_EN
            irq_seen_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_INIT_PL: if (bus_done_s) state_r <= ST_INIT_PH;
                ST_INIT_PH: if (bus_done_s) state_r <= ST_INIT_CTR;
                ST_INIT_CTR: begin
                    if (bus_done_s) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        rd_r        <= req_rd;
                        dev_r       <= req_dev;
                        reg_r       <= req_reg;
                        wdata_r     <= req_wdata;
                        step_r      <= 2'd0;
                        err_r       <= ERR_OK;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_WR_TXR;
                    end
                end
                ST_WR_TXR: if (bus_done_s) state_r <= ST_WR_CR;
                ST_WR_CR: begin
                    if (bus_done_s) begin
                        poll_cnt_r <= 16'd0;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
`ifdef I2C_REG_SEQ_IRQ_WAIT_EN
                    if (wb.wb_inta_i && !irq_seen_r) irq_seen_r <= 1'b1;
                    if (bus_done_s) irq_seen_r <= 1'b0;
`endif
                    if (bus_done_s && sr_if_s) begin
                        if (nack_s) begin
                            err_r   <= ERR_NACK;
                            state_r <= ST_STOP_CR;
                        end else if (last_s && rd_r) begin
                            state_r <= ST_RD_RXR;
                        end else if (last_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= ERR_OK;
                            state_r     <= ST_RESP;
                        end else begin
                            step_r  <= next_step_s;
                            state_r <= step_has_txr(next_step_s) ? ST_WR_TXR : ST_WR_CR;
                        end
                    end else if (wait_tick_s) begin
                        if (timeout_s) begin
                            err_r   <= ERR_TIMEOUT;
                            state_r <= ST_STOP_CR;
                        end else begin
                            poll_cnt_r <= poll_cnt_r + 16'd1;
                        end
                    end
                end
                ST_RD_RXR: begin
                    if (bus_done_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= ERR_OK;
                        rsp_rdata_r <= bus_rdata_s;
                        state_r     <= ST_RESP;
                    end
                end
                ST_STOP_CR: begin
                    if (bus_done_s) begin
                        poll_cnt_r <= 16'd0;
                        state_r    <= ST_STOP_WAIT;
                    end
                end
                ST_STOP_WAIT: begin
                    // A timeout here keeps the error that sent us down this path.
                    if (bus_done_s) begin
                        if (!bus_rdata_s[SR_BUSY] || timeout_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= err_r;
                            rsp_rdata_r <= 8'h00;
                            state_r     <= ST_RESP;
                        end else begin
                            poll_cnt_r <= poll_cnt_r + 16'd1;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_INIT_PL;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    logic unused_busy_s;
    assign unused_busy_s = bus_busy_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule
